pipe_control: RTL
=================

// Module: pipe_control
// PURPOSE
//  Pipelined LEGv8 control unit for the 5-stage core. Decodes the IF/ID instruction into control bits,
//  carries them through ID/EX, EX/MEM and MEM/WB control registers, detects load-use hazards
//  (stall + bubble) and clears in-flight control on branch flush. Feeds datapath muxes in ID/EX/MEM/WB.
// PARAMETERS
//  INSTR_LEN  32  instruction width
//  REG_W      5   register address width
//  ZERO_REG   31  XZR index; writes to it never create a hazard
//  HAZARD_EN  1   1: load-use detection active; 0: stall tied 0 (external scheduling)
// PORTS
//  clk             in   1          clock, rising edge
//  rst_n           in   1          asynchronous reset, active low
//  instruction     in   INSTR_LEN  IF/ID instruction
//  id_valid        in   1          IF/ID holds a real instruction
//  flush           in   1          branch taken (resolved in MEM): kill ID and EX
//  id_Reg2Loc      out  1          combinational, ID stage: read-port-2 select (Rt vs Rm)
//  stall           out  1          load-use stall: hold PC and IF/ID
//  illegal         out  1          combinational: id_valid and opcode not in table
//  ex_ALUSrc       out  1          EX controls
//  ex_ALUOp        out  2
//  mem_MemRead     out  1          MEM controls
//  mem_MemWrite    out  1
//  mem_Branch      out  1
//  mem_UncondBranch out 1
//  wb_RegWrite     out  1          WB controls
//  wb_MemtoReg     out  1
//  ex_rd           out  REG_W      destination reg of EX-stage instr (hazard/forwarding use)
// BEHAVIOUR
//  Decode (ID): LDUR op[31:21]=7C2 -> ALUSrc,MemtoReg,RegWrite,MemRead, ALUOp=00.
//   STUR 7C0 -> Reg2Loc,ALUSrc,MemWrite, ALUOp=00. ADD 458/SUB 658/AND 450/ORR 550 -> RegWrite, ALUOp=10.
//   CBZ op[31:24]=B4 -> Reg2Loc,Branch, ALUOp=01. B op[31:26]=05 -> UncondBranch. Other: all 0, illegal=1.
//   Unlisted bits = 0. id_valid=0 -> all-zero control (bubble), illegal=0.
//  Pipeline: each edge ID->EX->MEM->WB control regs shift; latency decode->ex_* 1 cycle, mem_* 2, wb_* 3.
//  Hazard (HAZARD_EN=1): stall = id_valid & ex MemRead & ex_rd!=ZERO_REG &
//   (ex_rd==instr[9:5] | ex_rd==(Reg2Loc ? instr[4:0] : instr[20:16])). Rn compare skipped for B.
//   On stall: ID/EX loads all-zero control (bubble); EX/MEM, MEM/WB advance normally; stall lasts 1 cycle.
//  Flush: ID/EX and EX/MEM load zero on the edge; MEM/WB advances normally. Flush dominates stall;
//   stall output forced 0 while flush=1.
//  Reset: all control regs, ex_rd, and thus every registered output = 0 asynchronously, mid-operation
//   included; first post-reset edge with id_valid=0 keeps bubbles flowing. Comb outputs follow inputs.
//  ex_rd = instr[4:0] captured with control; zeroed on bubble/flush.
// STRUCTURE
//  Opcode constants (11/8/6-bit) and ALUOp encodings go in definitions.vh alongside INSTR_LEN.
//  One sub-module: control_decode (pure combinational opcode table -> control bundle + illegal).
//  Top holds hazard compare and three control-register stages.
// TESTING
//  1 Decode: F84402C9,8B09026A,CB0A028B,F80602CB,B4000109,14000040,AA150149,8A0A02C9 one per cycle
//    -> ex_* 1 cycle later match table (e.g. LDUR ex_ALUSrc=1,ex_ALUOp=00; ADD ex_ALUOp=10).
//  2 Load-use: F84402C9 (LDUR X9) then 8B09026A (ADD Rm=X9) -> stall=1 one cycle, bubble in EX,
//    ADD reaches EX next cycle, wb_RegWrite/wb_MemtoReg sequence 1/1,0/0,1/0.
//  3 No hazard: LDUR XZR (F84003FF) then ADD using X31 -> stall=0.
//  4 Flush: STUR, ADD, flush=1 during ADD in EX and CBZ in ID -> mem_MemWrite of ADD slot 0,
//    CBZ never asserts mem_Branch; flush+stall same cycle -> stall=0.
//  5 Illegal: 0xDEADBEEF, id_valid=1 -> illegal=1, ex_* all 0; id_valid=0 -> illegal=0.
//  6 Reset mid-stream: rst_n low between edges with LDUR in MEM -> all outputs 0 immediately;
//    HAZARD_EN=0 build: case 2 gives stall=0.

Source files
------------

// File: rtl/pipe_control_pkg.sv
// Shared opcode constants, ALUOp encodings and per-stage control bundles
// for the pipelined LEGv8 control unit.
package pipe_control_pkg;

  localparam int DEF_INSTR_LEN = 32;
  localparam int DEF_REG_W     = 5;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

  typedef struct packed {
    logic   alu_src;
    aluop_e alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic uncond_branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_control_decode.sv
// Pure combinational opcode table: instruction opcode field -> control
// bundle, Reg2Loc select and illegal flag. Invalid slots decode to a bubble.
module pipe_control_decode
  import pipe_control_pkg::*;
(
  input  logic [10:0]  opcode_i,
  input  logic         valid_i,
  output stage_ctrl_t  ctrl_o,
  output logic         reg2loc_o,
  output logic         illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    reg2loc_o = 1'b0;
    illegal_o = 1'b0;
    if (valid_i) begin
      if (opcode_i == OP_LDUR) begin
        ctrl_o.ex.alu_src    = 1'b1;
        ctrl_o.mem.mem_read  = 1'b1;
        ctrl_o.wb.reg_write  = 1'b1;
        ctrl_o.wb.mem_to_reg = 1'b1;
      end else if (opcode_i == OP_STUR) begin
        reg2loc_o            = 1'b1;
        ctrl_o.ex.alu_src    = 1'b1;
        ctrl_o.mem.mem_write = 1'b1;
      end else if (opcode_i inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) begin
        ctrl_o.ex.alu_op    = ALUOP_RTYPE;
        ctrl_o.wb.reg_write = 1'b1;
      end else if (opcode_i[10:3] == OP_CBZ) begin
        reg2loc_o         = 1'b1;
        ctrl_o.ex.alu_op  = ALUOP_CBZ;
        ctrl_o.mem.branch = 1'b1;
      end else if (opcode_i[10:5] == OP_B) begin
        ctrl_o.mem.uncond_branch = 1'b1;
      end else begin
        illegal_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_control.sv
// Pipelined LEGv8 control unit: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, load-use stall detection and branch-flush clearing.
module pipe_control
  import pipe_control_pkg::*;
#(
  parameter int INSTR_LEN = DEF_INSTR_LEN,
  parameter int REG_W     = DEF_REG_W,
  parameter int ZERO_REG  = 31,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 id_valid,
  input  logic                 flush,
  output logic                 id_Reg2Loc,
  output logic                 stall,
  output logic                 illegal,
  output logic                 ex_ALUSrc,
  output logic [1:0]           ex_ALUOp,
  output logic                 mem_MemRead,
  output logic                 mem_MemWrite,
  output logic                 mem_Branch,
  output logic                 mem_UncondBranch,
  output logic                 wb_RegWrite,
  output logic                 wb_MemtoReg,
  output logic [REG_W-1:0]     ex_rd
);

  stage_ctrl_t      id_ctrl;
  stage_ctrl_t      ex_q, ex_d;
  mem_ctrl_t        mem_q, mem_d;
  wb_ctrl_t         mem_wb_q, mem_wb_d;
  wb_ctrl_t         wb_q, wb_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             hazard;

  wire [REG_W-1:0] id_rt = instruction[REG_W-1:0];
  wire [REG_W-1:0] id_rn = instruction[5 +: REG_W];
  wire [REG_W-1:0] id_rm = instruction[16 +: REG_W];

  // Shift/immediate bits never influence control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction[15:10];

  pipe_control_decode u_decode (
    .opcode_i  (instruction[31:21]),
    .valid_i   (id_valid),
    .ctrl_o    (id_ctrl),
    .reg2loc_o (id_Reg2Loc),
    .illegal_o (illegal)
  );

  generate
    if (HAZARD_EN) begin : g_hazard
      logic rn_hit, rm_hit;
      // B has no Rn operand, so its [9:5] field must not raise a stall.
      assign rn_hit = !id_ctrl.mem.uncond_branch && (ex_rd_q == id_rn);
      assign rm_hit = ex_rd_q == (id_Reg2Loc ? id_rt : id_rm);
      assign hazard = id_valid && ex_q.mem.mem_read &&
                      (ex_rd_q != REG_W'(ZERO_REG)) && (rn_hit || rm_hit);
    end else begin : g_no_hazard
      assign hazard = 1'b0;
    end
  endgenerate

  assign stall = hazard && !flush;

  always_comb begin
    ex_d     = id_ctrl;
    ex_rd_d  = id_rt;
    mem_d    = ex_q.mem;
    mem_wb_d = ex_q.wb;
    wb_d     = mem_wb_q;
    if (flush || stall || !id_valid || illegal) begin
      ex_d    = '0;
      ex_rd_d = '0;
    end
    if (flush) begin
      mem_d    = '0;
      mem_wb_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      ex_rd_q  <= '0;
      mem_q    <= '0;
      mem_wb_q <= '0;
      wb_q     <= '0;
    end else begin
      ex_q     <= ex_d;
      ex_rd_q  <= ex_rd_d;
      mem_q    <= mem_d;
      mem_wb_q <= mem_wb_d;
      wb_q     <= wb_d;
    end
  end

  assign ex_ALUSrc        = ex_q.ex.alu_src;
  assign ex_ALUOp         = ex_q.ex.alu_op;
  assign ex_rd            = ex_rd_q;
  assign mem_MemRead      = mem_q.mem_read;
  assign mem_MemWrite     = mem_q.mem_write;
  assign mem_Branch       = mem_q.branch;
  assign mem_UncondBranch = mem_q.uncond_branch;
  assign wb_RegWrite      = wb_q.reg_write;
  assign wb_MemtoReg      = wb_q.mem_to_reg;

endmodule
